// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// 32-iteration shift-add multiply / restoring divide, then a one-cycle sign fix-up.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic        is_div, neg, rneg;
  logic [31:0] ma, mb, araw;
  logic [63:0] acc;
  logic [32:0] rem;

  logic        sgn;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic        borrow;
  logic [63:0] prod;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !op[2]) state_n = RUN;
      RUN:     if (cnt == 5'd31) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sgn      = ~op[0];
    abs_a    = (sgn && a[31]) ? (~a + 32'd1) : a;
    abs_b    = (sgn && b[31]) ? (~b + 32'd1) : b;
    // Multiply: acc[31:0] holds the remaining multiplier bits, acc[63:32] the partial product.
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : '0);
    // Divide: acc[31:0] shifts the dividend out and the quotient in.
    div_sh   = {rem[31:0], acc[31]};
    div_diff = {1'b0, div_sh} - {2'b00, mb};
    borrow   = div_diff[33];
    prod     = neg  ? (~acc + 64'd1) : acc;
    q_fix    = neg  ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_fix    = rneg ? (~rem[31:0] + 32'd1) : rem[31:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                is_div <= op[1];
                ma     <= abs_a;
                mb     <= abs_b;
                araw   <= a;
                neg    <= sgn & (a[31] ^ b[31]);
                rneg   <= sgn & a[31];
                acc    <= op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
                rem    <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            rem        <= borrow ? div_sh : div_diff[32:0];
            acc[31:0]  <= {acc[30:0], ~borrow};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (is_div) begin
            if (mb == 32'd0) begin
              hi <= araw;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: stimulus pushes expected {hi,lo},
// a monitor pops and compares on every done pulse.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  mips_cpu_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int          npass = 0;
  int          ntotal = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: ref_model = sx * sy;
      3'd1: ref_model = ux * uy;
      3'd2: begin
        if (y == 32'd0) ref_model = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          ref_model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) ref_model = {x, 32'hFFFFFFFF};
        else ref_model = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  // Monitor: compares on done, tracks busy length, done width and HI/LO hold.
  int          bcnt = 0;
  logic        prev_done = 1'b0, prev_busy = 1'b0, held_bad = 1'b0;
  logic [31:0] h_prev = '0, l_prev = '0;
  logic [63:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      bcnt      = 0;
      prev_done = 1'b0;
      prev_busy = 1'b0;
      held_bad  = 1'b0;
    end else begin
      if (busy) bcnt++;
      if (busy && prev_busy && (hi !== h_prev || lo !== l_prev)) held_bad = 1'b1;
      if (done) begin
        done_seen++;
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("hilo", {hi, lo}, e);
          chk("busy_cycles", 64'(bcnt), 64'd33);
          chk("hold_during_busy", 64'(held_bad), 64'd0);
        end
        chk("done_width", 64'(prev_done), 64'd0);
        bcnt     = 0;
        held_bad = 1'b0;
      end
      prev_done = done;
      prev_busy = busy;
    end
    h_prev = hi;
    l_prev = lo;
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    op = o; a = x; b = y; start = 1'b1;
    if (o < 3'd4) begin
      r = ref_model(o, x, y);
      sb.push_back(r);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else if (o == 3'd4) m_hi = x;
    else if (o == 3'd5) m_lo = x;
    tick();
    start = 1'b0;
    if (o < 3'd4) begin
      chk("busy_after_accept", 64'(busy), 64'd1);
      wait_done();
      tick();
    end else begin
      chk("busy_reg_op", 64'(busy), 64'd0);
      chk("hilo_reg_op", {hi, lo}, {m_hi, m_lo});
    end
  endtask

  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Random activity, then a 2-cycle reset mid-operation.
    op = 3'd4; a = $urandom; start = 1'b1; tick();
    op = 3'd0; a = $urandom; b = $urandom; tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    issue(3'd4, 32'h12345678, 32'd0);

    // Directed cases.
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd3, 32'd7, 32'd0);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    issue(3'd2, 32'hFFFFFFF0, 32'd0);
    issue(3'd6, 32'hAAAA5555, 32'd1);

    // MTLO during RUN is ignored.
    sb.push_back({32'd0, 32'd15});
    m_hi = '0; m_lo = 32'd15;
    op = 3'd1; a = 32'd3; b = 32'd5; start = 1'b1; tick();
    start = 1'b0;
    repeat (9) tick();
    op = 3'd5; a = 32'h0000DEAD; start = 1'b1; tick();
    start = 1'b0;
    wait_done();
    tick();
    chk("ignored_mtlo", {hi, lo}, {32'd0, 32'd15});

    // Reset during RUN: result discarded, no done.
    d0 = done_seen;
    op = 3'd1; a = 32'd3; b = 32'd5; start = 1'b1; tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b0; tick();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (40) tick();
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);

    // Back-to-back with start held, second op presented on the done cycle.
    d0 = done_seen;
    sb.push_back({32'd0, 32'd6});
    op = 3'd1; a = 32'd2; b = 32'd3; start = 1'b1; tick();
    wait_done();
    sb.push_back({32'd1, 32'd2});
    op = 3'd3; a = 32'd9; b = 32'd4; tick();
    start = 1'b0;
    chk("b2b_accept_e34", 64'(busy), 64'd1);
    wait_done();
    tick();
    chk("b2b_final", {hi, lo}, {32'd1, 32'd2});
    chk("b2b_done_count", 64'(done_seen - d0), 64'd2);
    m_hi = 32'd1; m_lo = 32'd2;

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
    end

    repeat (3) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
